alu_arbiter: RTL and testbench

- Shares the single 64-bit integer ALU between two requesters: port 0 is the execute stage, port 1 is the address-generation/branch-compare path.
- Each cycle, a round-robin arbiter grants at most one request and drives the shared ALU's A, B and op from the granted requester.
- The ALU result and zero flag are captured into a per-requester response register with valid/ready backpressure.
- Sits between the pipeline front-end and the alu instance; the alu itself is unchanged and purely combinational.

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 64-bit ALU between the execute
// stage (port 0) and the address-generation/branch-compare path (port 1).
module alu_arbiter #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  logic              prio_q, prio_d;
  logic              r0_valid_q, r0_valid_d;
  logic              r1_valid_q, r1_valid_d;
  logic [DATA_W-1:0] r0_result_q, r0_result_d;
  logic [DATA_W-1:0] r1_result_q, r1_result_d;
  logic              r0_zero_q, r0_zero_d;
  logic              r1_zero_q, r1_zero_d;
  logic              elig0_s, elig1_s, grant0_s, grant1_s;

  // A requester may issue while its response slot is empty or being drained.
  assign elig0_s  = req0_valid && (!r0_valid_q || resp0_ready);
  assign elig1_s  = req1_valid && (!r1_valid_q || resp1_ready);
  assign grant0_s = elig0_s && (!elig1_s || !prio_q);
  assign grant1_s = elig1_s && (!elig0_s ||  prio_q);

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign resp0_valid  = r0_valid_q;
  assign resp0_result = r0_result_q;
  assign resp0_zero   = r0_zero_q;
  assign resp1_valid  = r1_valid_q;
  assign resp1_result = r1_result_q;
  assign resp1_zero   = r1_zero_q;

  // Shared ALU operand mux; idle drives AND of zeros.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    case ({grant1_s, grant0_s})
      2'b01: begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
      2'b10: begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
      end
    endcase
  end

  // Next state: priority passes to the loser; a grant overrides a consume.
  always_comb begin
    prio_d      = prio_q;
    r0_valid_d  = r0_valid_q;
    r0_result_d = r0_result_q;
    r0_zero_d   = r0_zero_q;
    r1_valid_d  = r1_valid_q;
    r1_result_d = r1_result_q;
    r1_zero_d   = r1_zero_q;

    if (grant0_s) begin
      prio_d = 1'b1;
    end else if (grant1_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end

    if (grant0_s) begin
      r0_valid_d  = 1'b1;
      r0_result_d = alu_result;
      r0_zero_d   = alu_zero;
    end else if (resp0_ready) begin
      r0_valid_d = 1'b0;
    end else begin
      r0_valid_d = r0_valid_q;
    end

    if (grant1_s) begin
      r1_valid_d  = 1'b1;
      r1_result_d = alu_result;
      r1_zero_d   = alu_zero;
    end else if (resp1_ready) begin
      r1_valid_d = 1'b0;
    end else begin
      r1_valid_d = r1_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q      <= 1'b0;
      r0_valid_q  <= 1'b0;
      r0_result_q <= '0;
      r0_zero_q   <= 1'b0;
      r1_valid_q  <= 1'b0;
      r1_result_q <= '0;
      r1_zero_q   <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      r0_valid_q  <= r0_valid_d;
      r0_result_q <= r0_result_d;
      r0_zero_q   <= r0_zero_d;
      r1_valid_q  <= r1_valid_d;
      r1_result_q <= r1_result_d;
      r1_zero_q   <= r1_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized checks of alu_arbiter against a transaction-level
// model; a behavioural ALU closes the loop on the alu_* ports.
module tb_alu_arbiter;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp0_zero;
  logic        resp1_valid, resp1_ready, resp1_zero;
  logic [63:0] resp0_result, resp1_result;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;

  int errors = 0;
  int checks = 0;

  // reference state
  int          m_prio;
  bit          m_valid [2];
  logic [63:0] m_res   [2];
  bit          m_zero  [2];

  alu_arbiter #(.DATA_W(64), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 CPZ (passes b), others 0
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return 64'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 64'd0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = 64'd0;
      m_zero[i]  = 1'b0;
    end
  endtask

  // One cycle: apply inputs, check grant/ALU drive, clock, check responses.
  task automatic step(input bit v0, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] op0,
                      input bit v1, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] op1,
                      input bit rr0, input bit rr1, output int g);
    bit          e0, e1;
    logic [63:0] ea, eb, r;
    logic [3:0]  eop;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    resp0_ready = rr0; resp1_ready = rr1;
    e0 = v0 && (!m_valid[0] || rr0);
    e1 = v1 && (!m_valid[1] || rr1);
    if (e0 && e1) g = m_prio;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;
    ea = 64'd0; eb = 64'd0; eop = 4'd0;
    if (g == 0) begin ea = a0; eb = b0; eop = op0; end
    if (g == 1) begin ea = a1; eb = b1; eop = op1; end
    #3;
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, g == 0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, g == 1});
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_op", {60'd0, alu_op}, {60'd0, eop});
    r = alu_fn(eop, ea, eb);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_valid[i] = 1'b1; m_res[i] = r; m_zero[i] = (r == 64'd0);
      end else if ((i == 0) ? rr0 : rr1) begin
        m_valid[i] = 1'b0;
      end
    end
    if (g >= 0) m_prio = 1 - g;
    #1;
    chk("resp0_valid",  {63'd0, resp0_valid}, {63'd0, m_valid[0]});
    chk("resp0_result", resp0_result, m_res[0]);
    chk("resp0_zero",   {63'd0, resp0_zero},  {63'd0, m_zero[0]});
    chk("resp1_valid",  {63'd0, resp1_valid}, {63'd0, m_valid[1]});
    chk("resp1_result", resp1_result, m_res[1]);
    chk("resp1_zero",   {63'd0, resp1_zero},  {63'd0, m_zero[1]});
  endtask

  initial begin
    int g;
    logic [3:0] ops [6];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1011;

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 64'd0; req0_b = 64'd0; req0_op = 4'd0;
    req1_valid = 1'b0; req1_a = 64'd0; req1_b = 64'd0; req1_op = 4'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp0_valid", {63'd0, resp0_valid}, 64'd0);
    chk("reset_resp1_valid", {63'd0, resp1_valid}, 64'd0);
    chk("reset_resp0_result", resp0_result, 64'd0);
    rst = 1'b0;

    // single ADD 5+7
    step(1'b1, 64'd5, 64'd7, 4'b0010, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 1'b1, g);
    chk("add_grant", 64'(g), 64'd0);
    chk("add_result", resp0_result, 64'd12);
    chk("add_zero", {63'd0, resp0_zero}, 64'd0);

    // CPZ on requester 1, b = 0
    step(1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 64'd3, 64'd0, 4'b0111, 1'b1, 1'b1, g);
    chk("cpz_zero", {63'd0, resp1_zero}, 64'd1);

    // idle: ALU driven with zeros, priority kept
    step(1'b0, 64'd1, 64'd2, 4'd2, 1'b0, 64'd3, 64'd4, 4'd2, 1'b1, 1'b1, g);

    // contention: SUB 9-9 vs ORR F0|0F, expect 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 64'd9, 64'd9, 4'b0110, 1'b1, 64'hF0, 64'h0F, 4'b0001, 1'b1, 1'b1, g);
      chk("contend_grant", 64'(g), 64'(k % 2));
    end
    chk("contend_r0", resp0_result, 64'd0);
    chk("contend_z0", {63'd0, resp0_zero}, 64'd1);
    chk("contend_r1", resp1_result, 64'hFF);

    // backpressure on requester 1: fill it, then hold resp1_ready low
    step(1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 64'd1, 64'd1, 4'b0010, 1'b1, 1'b0, g);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 64'(k), 64'd1, 4'b0010, 1'b1, 64'd10, 64'd20, 4'b0010, 1'b1, 1'b0, g);
      chk("bp_grant0", 64'(g), 64'd0);
    end
    step(1'b1, 64'd0, 64'd0, 4'b0010, 1'b1, 64'd10, 64'd20, 4'b0010, 1'b1, 1'b1, g);
    chk("bp_release_grant", 64'(g), 64'd1);
    chk("bp_release_valid", {63'd0, resp1_valid}, 64'd1);
    chk("bp_release_result", resp1_result, 64'd30);

    // wrap: all-ones + 1
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 1'b1, g);
    chk("wrap_result", resp0_result, 64'd0);
    chk("wrap_zero", {63'd0, resp0_zero}, 64'd1);

    // leave resp0 pending, then reset asynchronously mid-cycle
    step(1'b1, 64'd4, 64'd4, 4'b0010, 1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 1'b0, g);
    chk("pending_valid", {63'd0, resp0_valid}, 64'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, resp0_valid}, 64'd0);
    chk("async_rst_result", resp0_result, 64'd0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // prio back at 0: requester 0 wins a tie
    step(1'b1, 64'd1, 64'd1, 4'b0010, 1'b1, 64'd2, 64'd2, 4'b0010, 1'b1, 1'b1, g);
    chk("rst_prio_grant", 64'(g), 64'd0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [63:0] ra0, ra1;
      ra0 = {$urandom, $urandom};
      ra1 = {$urandom, $urandom};
      step($urandom_range(0, 3) != 0, ra0, ($urandom_range(0, 3) == 0) ? ra0 : {$urandom, $urandom},
           ops[$urandom_range(0, 5)],
           $urandom_range(0, 3) != 0, ra1, ($urandom_range(0, 3) == 0) ? ra1 : {$urandom, $urandom},
           ops[$urandom_range(0, 5)],
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
